gb_serial: RTL and testbench



---
 rtl/gb_serial_pkg.sv | 8 +
 rtl/gb_serial_sync.sv | 26 ++
 rtl/gb_serial.sv | 113 +++++++++++
 tb/tb_gb_serial.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_serial_pkg.sv
// gb_serial_pkg: shared types and constants for the gb_serial link controller
package gb_serial_pkg;
   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} ser_state_t;
   localparam logic [1:0] ADDR_SB = 2'b01;
   localparam logic [1:0] ADDR_SC = 2'b10;
   localparam logic [5:0] SC_MASK = 6'h3F;
   localparam int CLK_DIV_DEF = 512;
endpackage

// File: rtl/gb_serial_sync.sv
// gb_serial_sync: synchronizer for the external shift clock pin with registered edge pulses
//   clk, reset : core clock, async active-high reset
//   d          : asynchronous pin (idle high)
//   rise, fall : one-cycle pulses, registered, two clocks after the pin edge
module gb_serial_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise,
   output logic fall
);
   logic s1, s2;
   // flops reset high to match the idle pin level so reset release makes no edge
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         rise <= s1 & ~s2;
         fall <= ~s1 & s2;
      end
endmodule

// File: rtl/gb_serial.sv
// gb_serial: Game Boy serial link controller (SB/SC registers, shift engine, irq)
//   clk, reset         : core clock, async active-high reset
//   cpu_sel/addr/wr/di : register access (addr 01 = SB, 10 = SC)
//   cpu_do             : combinational read data
//   irq                : one-cycle transfer-complete pulse
//   ser_clk_in/out/oe  : link clock pin in, internal clock out, clock drive enable
//   ser_data_in/out    : link data pins
// Build option GB_SERIAL_LOOPBACK_EN: internal loopback of data and clock; input pins ignored.
module gb_serial
   import gb_serial_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_sel,
   input  logic [1:0] cpu_addr,
   input  logic       cpu_wr,
   input  logic [7:0] cpu_di,
   output logic [7:0] cpu_do,
   output logic       irq,
   input  logic       ser_clk_in,
   input  logic       ser_data_in,
   output logic       ser_clk_out,
   output logic       ser_data_out,
   output logic       ser_clk_oe
);
   localparam int HALF = CLK_DIV / 2;
   localparam int CW = $clog2(HALF);
   localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

   logic [7:0] sb;
   logic start, shiftclk;
   ser_state_t state;
   logic [CW-1:0] cnt;
   logic [3:0] bits;
   logic din, ext_rise, ext_fall;
   logic sb_wr, sc_wr, half_done, int_rise, int_fall, rise, fall;

`ifdef GB_SERIAL_LOOPBACK_EN
   logic clk_out_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) clk_out_q <= 1'b1;
      else clk_out_q <= ser_clk_out;
   assign din = ser_data_out;
   assign ext_rise = ser_clk_out & ~clk_out_q;
   assign ext_fall = ~ser_clk_out & clk_out_q;
`else
   assign din = ser_data_in;
   gb_serial_sync u_sync (
      .clk (clk),
      .reset (reset),
      .d (ser_clk_in),
      .rise (ext_rise),
      .fall (ext_fall)
   );
`endif

   assign sb_wr = cpu_sel & cpu_wr & (cpu_addr == ADDR_SB);
   assign sc_wr = cpu_sel & cpu_wr & (cpu_addr == ADDR_SC);
   assign half_done = cnt == HALF_END;
   assign int_rise = state == S_LOW && half_done;
   // a falling edge starts a bit: either leaving IDLE on a fresh start or ending a non-final HIGH
   assign int_fall = (state == S_IDLE && start && shiftclk) || (state == S_HIGH && half_done && bits != 4'd0);
   // an SC write takes priority over any shift edge in the same cycle
   assign rise = ~sc_wr & ((start & ~shiftclk & ext_rise) | int_rise);
   assign fall = ~sc_wr & ((start & ~shiftclk & ext_fall) | int_fall);
   assign cpu_do = cpu_addr == ADDR_SB ? sb : cpu_addr == ADDR_SC ? {start, SC_MASK, shiftclk} : 8'hFF;
   assign ser_clk_oe = shiftclk;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sb <= 8'h00;
         start <= 1'b0;
         shiftclk <= 1'b0;
         irq <= 1'b0;
         state <= S_IDLE;
         cnt <= '0;
         bits <= 4'd0;
         ser_clk_out <= 1'b1;
         ser_data_out <= 1'b1;
      end else begin
         irq <= 1'b0;
         // a CPU write to SB drops the coinciding shift; the bit count below still advances
         if (sb_wr) sb <= cpu_di;
         else if (rise) sb <= {sb[6:0], din};
         if (fall) ser_data_out <= sb[7];
         if (sc_wr) begin
            start <= cpu_di[7];
            shiftclk <= cpu_di[0];
            bits <= cpu_di[7] ? 4'd8 : 4'd0;
            state <= S_IDLE;
            cnt <= '0;
            ser_clk_out <= 1'b1;
         end else begin
            if (rise) begin
               bits <= bits - 4'd1;
               if (bits == 4'd1) begin
                  start <= 1'b0;
                  irq <= 1'b1;
               end
            end
            cnt <= (state == S_IDLE || half_done) ? '0 : cnt + CW'(1);
            if (int_fall) begin
               state <= S_LOW;
               ser_clk_out <= 1'b0;
            end else if (int_rise) begin
               state <= S_HIGH;
               ser_clk_out <= 1'b1;
            end else if (state == S_HIGH && half_done) state <= S_IDLE;
         end
      end
endmodule

// File: tb/tb_gb_serial.sv
// tb_gb_serial: randomized scoreboard bench for gb_serial (internal, pin loopback, external, abort, collision, reset)
`timescale 1ns/1ps
module tb_gb_serial;
   import gb_serial_pkg::*;
   localparam int CLK_DIV = 16;
   localparam int HALF = CLK_DIV / 2;

   logic clk = 1'b0;
   logic reset;
   logic cpu_sel, cpu_wr;
   logic [1:0] cpu_addr;
   logic [7:0] cpu_di, cpu_do;
   logic irq, ser_clk_in, ser_data_in, ser_clk_out, ser_data_out, ser_clk_oe;

   int total = 0, bad = 0, cyc = 0, t0 = 0, irq_cnt = 0, din_mode = 0;
   logic ext_bit = 1'b1;
   logic [7:0] rx_cur = 8'hFF;

   typedef struct { logic [7:0] sb; logic [7:0] dout; bit chk_dout; int cyc; } exp_t;
   exp_t q[$];
   exp_t e;

   gb_serial #(.CLK_DIV(CLK_DIV)) dut (
      .clk (clk),
      .reset (reset),
      .cpu_sel (cpu_sel),
      .cpu_addr (cpu_addr),
      .cpu_wr (cpu_wr),
      .cpu_di (cpu_di),
      .cpu_do (cpu_do),
      .irq (irq),
      .ser_clk_in (ser_clk_in),
      .ser_data_in (ser_data_in),
      .ser_clk_out (ser_clk_out),
      .ser_data_out (ser_data_out),
      .ser_clk_oe (ser_clk_oe)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // rising shift edge k lands on clock edge t+1+HALF+k*CLK_DIV; present bit k of the partner byte before it
   function automatic int bit_idx(int c, int t);
      int r0 = t + 1 + HALF;
      int k;
      if (c + 1 <= r0) return 0;
      k = (c + 1 - r0 + CLK_DIV - 1) / CLK_DIV;
      return k > 7 ? 7 : k;
   endfunction

   assign ser_data_in = din_mode == 2 ? ser_data_out : din_mode == 1 ? rx_cur[3'(7 - bit_idx(cyc, t0))] : ext_bit;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic wr(logic [1:0] a, logic [7:0] d);
      @(negedge clk);
      cpu_addr = a;
      cpu_di = d;
      cpu_wr = 1'b1;
      if (a == ADDR_SC) t0 = cyc + 1;
      @(negedge clk);
      cpu_wr = 1'b0;
      cpu_addr = ADDR_SB;
   endtask

   task automatic rd(logic [1:0] a, logic [7:0] exp, string name);
      @(negedge clk);
      cpu_addr = a;
      #1 chk(name, cpu_do, exp);
      @(negedge clk);
      cpu_addr = ADDR_SB;
   endtask

   task automatic pulse(logic b, bit last, logic [7:0] exp_sb);
      @(negedge clk);
      ser_clk_in = 1'b0;
      ext_bit = b;
      repeat (6) @(negedge clk);
      ser_clk_in = 1'b1;
      if (last) q.push_back('{exp_sb, 8'h00, 1'b0, cyc + 3});
      repeat (6) @(negedge clk);
   endtask

   // monitor: tracks the shift clock and pops the scoreboard on every irq
   logic clk_prev = 1'b1, irq_prev = 1'b0;
   int fall_cyc = 0;
   logic [7:0] dsh = 8'h00;
   always @(negedge clk) begin
      #4;
      if (reset) begin
         clk_prev = 1'b1;
         irq_prev = 1'b0;
      end else begin
         if (!ser_clk_out && clk_prev) fall_cyc = cyc;
         if (ser_clk_out && !clk_prev) begin
            dsh = {dsh[6:0], ser_data_out};
            if (q.size() > 0) chk("low_width", cyc - fall_cyc, HALF);
         end
         if (irq) begin
            irq_cnt++;
            chk("irq_single", irq_prev, 0);
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL irq_unexpected: got irq want none at cycle %0d", cyc);
            end else begin
               e = q.pop_front();
               chk("irq_cycle", cyc, e.cyc);
               chk("sb_at_irq", cpu_do, e.sb);
               if (e.chk_dout) chk("dout_seq", dsh, e.dout);
            end
         end
         clk_prev = ser_clk_out;
         irq_prev = irq;
      end
   end

   initial begin
      logic [7:0] tx, rx, w, part;
      int n0;
      reset = 1'b1;
      cpu_sel = 1'b1;
      cpu_wr = 1'b0;
      cpu_addr = ADDR_SB;
      cpu_di = 8'h00;
      ser_clk_in = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_sb", cpu_do, 8'h00);
      chk("rst_irq", irq, 0);
      chk("rst_clk_out", ser_clk_out, 1);
      chk("rst_dout", ser_data_out, 1);
      chk("rst_oe", ser_clk_oe, 0);
      cpu_addr = ADDR_SC;
      #1 chk("rst_sc", cpu_do, 8'h7E);
      cpu_addr = 2'b00;
      #1 chk("rd_other", cpu_do, 8'hFF);
      cpu_addr = ADDR_SB;
      reset = 1'b0;

      // internal clock, partner byte driven on the data pin
      din_mode = 1;
      for (int i = 0; i < 6; i++) begin
         tx = i == 0 ? 8'hA5 : 8'($urandom);
         rx = i == 0 ? 8'hFF : 8'($urandom);
         wr(ADDR_SB, tx);
         rx_cur = rx;
         wr(ADDR_SC, 8'h81);
         q.push_back('{rx, tx, 1'b1, t0 + 1 + HALF + 7 * CLK_DIV});
         repeat (8 * CLK_DIV + 4) @(negedge clk);
         chk("irq_seen", q.size(), 0);
         rd(ADDR_SC, 8'h7F, "sc_after");
      end

      // data pins tied together: the byte comes back unchanged
      din_mode = 2;
      for (int i = 0; i < 2; i++) begin
         tx = i == 0 ? 8'h3C : 8'($urandom);
         wr(ADDR_SB, tx);
         wr(ADDR_SC, 8'h81);
         q.push_back('{tx, tx, 1'b1, t0 + 1 + HALF + 7 * CLK_DIV});
         repeat (8 * CLK_DIV + 4) @(negedge clk);
         chk("loop_irq_seen", q.size(), 0);
      end

      // external clock: pulses before start are ignored, then 8 pulses complete a transfer
      din_mode = 0;
      for (int i = 0; i < 2; i++) begin
         rx = i == 0 ? 8'h00 : 8'($urandom);
         wr(ADDR_SB, 8'hC3);
         wr(ADDR_SC, 8'h00);
         n0 = irq_cnt;
         for (int j = 0; j < 3; j++) pulse(1'b0, 1'b0, 8'h00);
         rd(ADDR_SB, 8'hC3, "ext_ignored_sb");
         chk("ext_ignored_irq", irq_cnt, n0);
         wr(ADDR_SC, 8'h80);
         for (int j = 0; j < 8; j++) pulse(rx[3'(7 - j)], j == 7, rx);
         repeat (4) @(negedge clk);
         chk("ext_irq_seen", q.size(), 0);
         chk("ext_one_irq", irq_cnt, n0 + 1);
         rd(ADDR_SC, 8'h7E, "ext_sc_after");
      end

      // abort after three bits, then restart
      din_mode = 1;
      tx = 8'($urandom);
      rx = 8'($urandom);
      wr(ADDR_SB, tx);
      rx_cur = rx;
      wr(ADDR_SC, 8'h81);
      n0 = irq_cnt;
      while (cyc < t0 + 1 + HALF + 2 * CLK_DIV) @(negedge clk);
      wr(ADDR_SC, 8'h01);
      repeat (10 * CLK_DIV) @(negedge clk);
      chk("abort_no_irq", irq_cnt, n0);
      rd(ADDR_SC, 8'h7F, "abort_sc");
      part = {tx[4:0], rx[7:5]};
      rd(ADDR_SB, part, "abort_sb");
      rx = 8'($urandom);
      rx_cur = rx;
      wr(ADDR_SC, 8'h81);
      q.push_back('{rx, part, 1'b1, t0 + 1 + HALF + 7 * CLK_DIV});
      repeat (8 * CLK_DIV + 4) @(negedge clk);
      chk("restart_one_irq", irq_cnt, n0 + 1);

      // SB write on the same edge as rising shift edge 4
      tx = 8'($urandom);
      rx = 8'($urandom);
      w = 8'h55;
      wr(ADDR_SB, tx);
      rx_cur = rx;
      wr(ADDR_SC, 8'h81);
      q.push_back('{{w[4:0], rx[2:0]}, {tx[7:3], w[7:5]}, 1'b1, t0 + 1 + HALF + 7 * CLK_DIV});
      while (cyc < t0 + 1 + HALF + 4 * CLK_DIV - 2) @(negedge clk);
      wr(ADDR_SB, w);
      #1 chk("collide_hold", cpu_do, w);
      repeat (8 * CLK_DIV) @(negedge clk);
      chk("collide_irq_seen", q.size(), 0);

      // asynchronous reset mid-transfer
      wr(ADDR_SB, 8'($urandom));
      wr(ADDR_SC, 8'h81);
      n0 = irq_cnt;
      repeat (3 * CLK_DIV) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_irq", irq, 0);
      chk("mid_rst_clk_out", ser_clk_out, 1);
      chk("mid_rst_dout", ser_data_out, 1);
      chk("mid_rst_oe", ser_clk_oe, 0);
      chk("mid_rst_sb", cpu_do, 8'h00);
      cpu_addr = ADDR_SC;
      #1 chk("mid_rst_sc", cpu_do, 8'h7E);
      cpu_addr = ADDR_SB;
      @(negedge clk);
      reset = 1'b0;
      repeat (10 * CLK_DIV) @(negedge clk);
      chk("mid_rst_no_irq", irq_cnt, n0);
      rd(ADDR_SC, 8'h7E, "mid_rst_sc_after");

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
